// File: rtl/frame_loader.sv
// Writer side of the pixel frame memory: takes a raster-order pixel stream over
// valid/ready and produces the write strobe, address and data, flagging when a full frame is resident.
module frame_loader #(
   parameter int COL = 40,
   parameter int ROW = 25
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       Start,
   input  logic       Abort,
   input  logic [7:0] PixIn,
   input  logic       PixValid,
   output logic       PixReady,
   output logic       WE,
   output logic [9:0] WA,
   output logic [7:0] D,
   output logic [6:0] XCnt,
   output logic [5:0] YCnt,
   output logic       Busy,
   output logic       FrameDone,
   output logic       FrameValid
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

   state_t     state_r;
   state_t     state_s;
   logic [9:0] addr_r;
   logic       accept_s;
   logic       last_s;
   logic       enter_load_s;

   // Next-state decode; Abort always takes priority over Start and over a last-pixel accept
   always_comb begin
      state_s      = state_r;
      accept_s     = 1'b0;
      enter_load_s = 1'b0;
      last_s       = (XCnt == 7'(COL - 1)) && (YCnt == 6'(ROW - 1));
      case (state_r)
         IDLE: begin
            if (Abort) begin
               state_s = IDLE;
            end else if (Start) begin
               state_s      = LOAD;
               enter_load_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            if (Abort) begin
               state_s = IDLE;
            end else if (PixValid && PixReady) begin
               accept_s = 1'b1;
               if (last_s) begin
                  state_s = DONE;
               end else begin
                  state_s = LOAD;
               end
            end else begin
               state_s = LOAD;
            end
         end
         DONE: begin
            if (Abort) begin
               state_s = IDLE;
            end else if (Start) begin
               state_s      = LOAD;
               enter_load_s = 1'b1;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register and registered status outputs, all derived from the next state
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_r    <= IDLE;
         PixReady   <= 1'b0;
         Busy       <= 1'b0;
         WE         <= 1'b0;
         FrameDone  <= 1'b0;
         FrameValid <= 1'b0;
      end else begin
         state_r    <= state_s;
         PixReady   <= (state_s == LOAD);
         Busy       <= (state_s == LOAD);
         WE         <= accept_s;
         FrameDone  <= accept_s && (state_s == DONE);
         FrameValid <= (state_s == DONE);
      end
   end

   // Memory write address/data capture; held between accepts
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         WA <= 10'd0;
         D  <= 8'd0;
      end else if (accept_s) begin
         WA <= addr_r;
         D  <= PixIn;
      end else begin
         WA <= WA;
         D  <= D;
      end
   end

   // Raster position and linear address of the next pixel
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         addr_r <= 10'd0;
         XCnt   <= 7'd0;
         YCnt   <= 6'd0;
      end else if (enter_load_s) begin
         addr_r <= 10'd0;
         XCnt   <= 7'd0;
         YCnt   <= 6'd0;
      end else if (accept_s) begin
         addr_r <= addr_r + 10'd1;
         if (last_s) begin
            XCnt <= 7'd0;
            YCnt <= 6'd0;
         end else if (XCnt == 7'(COL - 1)) begin
            XCnt <= 7'd0;
            YCnt <= YCnt + 6'd1;
         end else begin
            XCnt <= XCnt + 7'd1;
            YCnt <= YCnt;
         end
      end else begin
         addr_r <= addr_r;
         XCnt   <= XCnt;
         YCnt   <= YCnt;
      end
   end

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader on a 4x3 frame: the driver queues each expected
// write as it presents an accepted pixel; a negedge monitor pops and compares on every WE.
module tb_frame_loader;

   localparam int COL = 4;
   localparam int ROW = 3;

   logic       Clk = 1'b0;
   logic       Reset_n, Start, Abort, PixValid;
   logic [7:0] PixIn;
   logic       PixReady, WE, Busy, FrameDone, FrameValid;
   logic [9:0] WA;
   logic [7:0] D;
   logic [6:0] XCnt;
   logic [5:0] YCnt;

   int errors = 0;
   int checks = 0;
   bit run = 1'b0;

   typedef struct {
      logic [9:0] wa;
      logic [7:0] d;
      logic       fin;
   } exp_t;

   exp_t sb[$];

   frame_loader #(.COL(COL), .ROW(ROW)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
      .PixIn(PixIn), .PixValid(PixValid), .PixReady(PixReady),
      .WE(WE), .WA(WA), .D(D), .XCnt(XCnt), .YCnt(YCnt),
      .Busy(Busy), .FrameDone(FrameDone), .FrameValid(FrameValid)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every write must match the oldest queued expectation
   always @(negedge Clk) begin
      if (run) begin
         if (WE === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual WA=%0d D=%0h required no write at %0t", WA, D, $time);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("wa", 32'(WA), 32'(e.wa));
               chk("d", 32'(D), 32'(e.d));
               chk("frame_done_on_write", 32'(FrameDone), 32'(e.fin));
            end
         end else begin
            chk("frame_done_idle", 32'(FrameDone), 32'd0);
         end
      end
   end

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_reset_outputs;
      chk("rst_pix_ready", 32'(PixReady), 32'd0);
      chk("rst_we", 32'(WE), 32'd0);
      chk("rst_wa", 32'(WA), 32'd0);
      chk("rst_d", 32'(D), 32'd0);
      chk("rst_xcnt", 32'(XCnt), 32'd0);
      chk("rst_ycnt", 32'(YCnt), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_frame_done", 32'(FrameDone), 32'd0);
      chk("rst_frame_valid", 32'(FrameValid), 32'd0);
   endtask

   task automatic start_frame;
      Start = 1'b1;
      tick;
      Start = 1'b0;
      chk("start_busy", 32'(Busy), 32'd1);
      chk("start_pix_ready", 32'(PixReady), 32'd1);
      chk("start_frame_valid", 32'(FrameValid), 32'd0);
      chk("start_xcnt", 32'(XCnt), 32'd0);
      chk("start_ycnt", 32'(YCnt), 32'd0);
   endtask

   task automatic send(input logic [7:0] data, input int addr, input bit fin);
      chk("pix_ready", 32'(PixReady), 32'd1);
      chk("xcnt", 32'(XCnt), 32'(addr % COL));
      chk("ycnt", 32'(YCnt), 32'(addr / COL));
      PixValid = 1'b1;
      PixIn    = data;
      sb.push_back('{wa: 10'(addr), d: data, fin: fin});
      tick;
      PixValid = 1'b0;
   endtask

   task automatic frame(input logic [7:0] base, input bit gaps, input int start_at);
      for (int n = 0; n < COL * ROW; n++) begin
         if (n == start_at) Start = 1'b1;
         send(base + 8'(n), n, n == COL * ROW - 1);
         Start = 1'b0;
         if (gaps && (n % 3 == 0) && (n != COL * ROW - 1)) begin
            tick;
            tick;
         end
      end
      chk("end_pix_ready", 32'(PixReady), 32'd0);
      chk("end_busy", 32'(Busy), 32'd0);
      chk("end_frame_valid", 32'(FrameValid), 32'd1);
      chk("end_xcnt", 32'(XCnt), 32'd0);
      chk("end_ycnt", 32'(YCnt), 32'd0);
   endtask

   initial begin
      Reset_n  = 1'b0;
      Start    = 1'b0;
      Abort    = 1'b0;
      PixValid = 1'b0;
      PixIn    = 8'h00;
      tick;
      tick;
      chk_reset_outputs();
      Reset_n = 1'b1;
      run     = 1'b1;

      // valid data without Start must not be written
      PixValid = 1'b1;
      PixIn    = 8'hAA;
      tick;
      tick;
      tick;
      PixValid = 1'b0;
      chk("idle_pix_ready", 32'(PixReady), 32'd0);
      chk("idle_busy", 32'(Busy), 32'd0);

      Abort = 1'b1;
      tick;
      Abort = 1'b0;
      chk("idle_abort_busy", 32'(Busy), 32'd0);
      chk("idle_abort_valid", 32'(FrameValid), 32'd0);

      // continuous frame
      start_frame();
      frame(8'h10, 1'b0, -1);
      tick;
      chk("hold_frame_valid", 32'(FrameValid), 32'd1);
      chk("sb_empty_cont", 32'(sb.size()), 32'd0);

      // restart from DONE with a stalled stream
      start_frame();
      frame(8'h40, 1'b1, -1);
      tick;
      chk("sb_empty_stall", 32'(sb.size()), 32'd0);

      // Start at pixel 5 is ignored
      start_frame();
      frame(8'h80, 1'b0, 5);
      tick;
      chk("sb_empty_start", 32'(sb.size()), 32'd0);

      // Abort at pixel 7
      start_frame();
      for (int n = 0; n < 7; n++) send(8'h20 + 8'(n), n, 1'b0);
      PixValid = 1'b1;
      PixIn    = 8'h27;
      Abort    = 1'b1;
      tick;
      Abort    = 1'b0;
      PixValid = 1'b0;
      chk("abort_pix_ready", 32'(PixReady), 32'd0);
      chk("abort_busy", 32'(Busy), 32'd0);
      chk("abort_frame_valid", 32'(FrameValid), 32'd0);
      tick;
      tick;
      chk("sb_empty_abort", 32'(sb.size()), 32'd0);

      // Abort on the last-pixel edge
      start_frame();
      for (int n = 0; n < COL * ROW - 1; n++) send(8'h30 + 8'(n), n, 1'b0);
      PixValid = 1'b1;
      PixIn    = 8'h3B;
      Abort    = 1'b1;
      tick;
      Abort    = 1'b0;
      PixValid = 1'b0;
      chk("abort_last_frame_valid", 32'(FrameValid), 32'd0);
      chk("abort_last_pix_ready", 32'(PixReady), 32'd0);
      tick;
      chk("abort_last_frame_valid2", 32'(FrameValid), 32'd0);
      chk("sb_empty_abort_last", 32'(sb.size()), 32'd0);

      // reset at pixel 6
      start_frame();
      for (int n = 0; n < 6; n++) send(8'h50 + 8'(n), n, 1'b0);
      PixValid = 1'b1;
      PixIn    = 8'h56;
      Reset_n  = 1'b0;
      tick;
      chk_reset_outputs();
      Reset_n  = 1'b1;
      PixValid = 1'b0;
      tick;
      chk("sb_empty_reset", 32'(sb.size()), 32'd0);

      // fresh frame, then Start from DONE for a second one
      start_frame();
      frame(8'hC0, 1'b0, -1);
      tick;
      start_frame();
      frame(8'hE0, 1'b0, -1);
      tick;
      chk("sb_empty_final", 32'(sb.size()), 32'd0);

      run = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
